// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and widths for the CPU/VEC unified-memory arbiter.
// Contents: bus widths, FSM state encoding, owner encoding.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VEC = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_pick2.sv
// Purpose: combinational 2-way winner select for the memory arbiter.
// Ports:
//   req_cpu    in   CPU request pending
//   req_vec    in   VEC request pending
//   last_owner in   owner of the most recent completed transaction
//   prio_mode  in   0 = round-robin on ties, 1 = VEC wins every tie
//   win_vec    out  1 when VEC gets the grant (only meaningful with a request)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic   req_cpu,
    input  logic   req_vec,
    input  owner_e last_owner,
    input  logic   prio_mode,
    output logic   win_vec
);

    // Lone requester wins; on a tie either VEC has priority or the side
    // that did not own the memory last time goes next.
    always_comb begin
        win_vec = 1'b0;
        if (req_vec && !req_cpu) begin
            win_vec = 1'b1;
        end else if (req_vec && req_cpu) begin
            win_vec = prio_mode ? 1'b1 : (last_owner == OWN_CPU);
        end
    end

endmodule

// File: rtl/vec_cpu_mem_arbiter.sv
// Purpose: shares one single-ported memory between the picorv32 native port
//   (CPU) and the vector coprocessor load/store port (VEC). One transaction is
//   forwarded at a time; out-of-range requests are answered locally.
// Parameters:
//   MEM_BYTES  mapped size in bytes; addr >= MEM_BYTES never goes downstream
//   PRIO_MODE  0 = round-robin on ties, 1 = VEC always wins ties
// Ports:
//   clk, reset                       clock, async active-high reset
//   cpu_mem_* (valid/instr/addr/wdata/wstrb in, ready/rdata out)  CPU port
//   vec_mem_* (valid/addr/wdata/wstrb in, ready/rdata out)        VEC port
//   mem_* (valid/instr/addr/wdata/wstrb out, ready/rdata in)      memory port
//   grant_vec  out  1 while VEC owns the memory
//   oob_err    out  one-cycle pulse when an out-of-range request is answered
module vec_cpu_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_mem_valid,
    input  logic              cpu_mem_instr,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_wdata,
    input  logic [STRB_W-1:0] cpu_mem_wstrb,
    output logic              cpu_mem_ready,
    output logic [DATA_W-1:0] cpu_mem_rdata,

    input  logic              vec_mem_valid,
    input  logic [ADDR_W-1:0] vec_mem_addr,
    input  logic [DATA_W-1:0] vec_mem_wdata,
    input  logic [STRB_W-1:0] vec_mem_wstrb,
    output logic              vec_mem_ready,
    output logic [DATA_W-1:0] vec_mem_rdata,

    output logic              mem_valid,
    output logic              mem_instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              grant_vec,
    output logic              oob_err
);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_owner_q;
    logic              valid_q;
    logic              instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              grant_vec_q;
    logic              oob_err_q;

    logic              win_vec;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [STRB_W-1:0] win_wstrb;
    logic              win_instr;
    logic              win_oob;
    logic              resp_c;
    logic [DATA_W-1:0] resp_rdata_c;

    rr_pick2 u_pick (
        .req_cpu    (cpu_mem_valid),
        .req_vec    (vec_mem_valid),
        .last_owner (last_owner_q),
        .prio_mode  (PRIO_MODE != 0),
        .win_vec    (win_vec)
    );

    // Winner's request fields; VEC never issues instruction fetches.
    always_comb begin
        win_addr  = win_vec ? vec_mem_addr  : cpu_mem_addr;
        win_wdata = win_vec ? vec_mem_wdata : cpu_mem_wdata;
        win_wstrb = win_vec ? vec_mem_wstrb : cpu_mem_wstrb;
        win_instr = win_vec ? 1'b0          : cpu_mem_instr;
        win_oob   = (win_addr >= ADDR_W'(MEM_BYTES));
    end

    // Arbitration FSM with registered downstream request and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_CPU;
            valid_q      <= 1'b0;
            instr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            grant_vec_q  <= 1'b0;
            oob_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_mem_valid || vec_mem_valid) begin
                        addr_q      <= win_addr;
                        wdata_q     <= win_wdata;
                        wstrb_q     <= win_wstrb;
                        instr_q     <= win_instr;
                        owner_q     <= win_vec ? OWN_VEC : OWN_CPU;
                        grant_vec_q <= win_vec;
                        if (win_oob) begin
                            oob_err_q <= 1'b1;
                            state_q   <= ST_ERR;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        valid_q      <= 1'b0;
                        last_owner_q <= owner_q;
                        grant_vec_q  <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    // A locally answered request still counts as a turn, so a
                    // master spinning on bad addresses cannot starve the other.
                    oob_err_q    <= 1'b0;
                    last_owner_q <= owner_q;
                    grant_vec_q  <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    valid_q     <= 1'b0;
                    grant_vec_q <= 1'b0;
                    oob_err_q   <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion is routed only to the owner; ERR answers with zero data.
    always_comb begin
        cpu_mem_ready = 1'b0;
        vec_mem_ready = 1'b0;
        cpu_mem_rdata = '0;
        vec_mem_rdata = '0;
        resp_c        = ((state_q == ST_BUSY) && mem_ready) || (state_q == ST_ERR);
        resp_rdata_c  = (state_q == ST_BUSY) ? mem_rdata : '0;
        if (resp_c) begin
            if (owner_q == OWN_VEC) begin
                vec_mem_ready = 1'b1;
                vec_mem_rdata = resp_rdata_c;
            end else begin
                cpu_mem_ready = 1'b1;
                cpu_mem_rdata = resp_rdata_c;
            end
        end
    end

    assign mem_valid = valid_q;
    assign mem_instr = instr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign grant_vec = grant_vec_q;
    assign oob_err   = oob_err_q;

endmodule

// File: tb/tb_vec_cpu_mem_arbiter.sv
module tb_vec_cpu_mem_arbiter;

    localparam int unsigned MEM_BYTES = 1024;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_valid, cpu_mem_instr, cpu_mem_ready;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        vec_mem_valid, vec_mem_ready;
    logic [31:0] vec_mem_addr, vec_mem_wdata, vec_mem_rdata;
    logic [3:0]  vec_mem_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        grant_vec, oob_err;

    logic        mem_ready_m  = 1'b0;
    logic        inject_ready = 1'b0;
    int unsigned dly = 0;
    bit          lat_en = 1'b0;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    int tests = 0;
    int fails = 0;

    req_t        cpu_q[$], vec_q[$];
    req_t        cur [2];
    bit          pend [2];
    int          age [2];
    int          wait_f [2];
    int          first_lat [2];
    logic [31:0] res_cpu[$], res_vec[$];
    int          order[$];
    logic        gv[$];
    int          mv_cycles, oob_cnt;
    logic [3:0]  last_vec_wstrb;

    always #5 clk = ~clk;

    assign mem_ready = mem_ready_m | inject_ready;

    vec_cpu_mem_arbiter #(.MEM_BYTES(MEM_BYTES), .PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
        .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
        .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .grant_vec(grant_vec), .oob_err(oob_err)
    );

    // picorv32-style memory: ready one cycle after valid, optional extra wait states
    always @(posedge clk) begin
        if (mem_valid && !mem_ready_m) begin
            if (dly != 0) begin
                dly <= dly - 1;
            end else begin
                mem_ready_m <= 1'b1;
                mem_rdata   <= mem[mem_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                dly <= lat_en ? $urandom_range(0, 2) : 0;
            end
        end else begin
            mem_ready_m <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_le(input string tag, input int obs, input int lim);
        tests++;
        assert (obs <= lim) else begin
            fails++;
            $error("FAIL %s: observed %0d expected <= %0d", tag, obs, lim);
        end
    endtask

    task automatic drive();
        cpu_mem_valid = pend[0];
        cpu_mem_addr  = cur[0].addr;
        cpu_mem_wdata = cur[0].wdata;
        cpu_mem_wstrb = cur[0].wstrb;
        cpu_mem_instr = cur[0].instr;
        vec_mem_valid = pend[1];
        vec_mem_addr  = cur[1].addr;
        vec_mem_wdata = cur[1].wdata;
        vec_mem_wstrb = cur[1].wstrb;
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic i);
        req_t r;
        r.addr = a; r.wdata = d; r.wstrb = s; r.instr = i;
        return r;
    endfunction

    // Runs both request queues as two masters against a shadow memory; call at posedge+1.
    task automatic run_traffic(input int max_cyc, input bit gaps);
        bit          rdy [2];
        logic [31:0] rd [2];
        logic [31:0] expd;
        bit          abort = 1'b0;
        bit          oob;
        int          gi;
        res_cpu.delete(); res_vec.delete(); order.delete(); gv.delete();
        mv_cycles = 0; oob_cnt = 0; last_vec_wstrb = '0;
        first_lat[0] = -1; first_lat[1] = -1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < max_cyc && !abort; c++) begin
            if (!pend[0] && cpu_q.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                cur[0] = cpu_q.pop_front(); pend[0] = 1'b1; age[0] = 0; wait_f[0] = 0;
            end
            if (!pend[1] && vec_q.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                cur[1] = vec_q.pop_front(); pend[1] = 1'b1; age[1] = 0; wait_f[1] = 0;
            end
            drive();
            @(negedge clk);
            rdy[0] = cpu_mem_ready; rdy[1] = vec_mem_ready;
            rd[0]  = cpu_mem_rdata; rd[1]  = vec_mem_rdata;
            oob_cnt += int'(oob_err);
            check("dual_ready", 32'(rdy[0] & rdy[1]), 32'd0);
            if (mem_valid) begin
                gi = grant_vec ? 1 : 0;
                mv_cycles++;
                check("ds_owner_pending", 32'(pend[gi]), 32'd1);
                check("ds_addr", mem_addr, cur[gi].addr);
                check("ds_wdata", mem_wdata, cur[gi].wdata);
                check("ds_wstrb", 32'(mem_wstrb), 32'(cur[gi].wstrb));
                check("ds_instr", 32'(mem_instr), (gi == 0) ? 32'(cur[0].instr) : 32'd0);
                if (gi == 1) last_vec_wstrb = mem_wstrb;
            end
            if (!rdy[0] && !rdy[1]) check("oob_idle", 32'(oob_err), 32'd0);
            for (int m = 0; m < 2; m++) begin
                if (rdy[m]) begin
                    check("ready_owner", 32'(pend[m]), 32'd1);
                    check("other_rdata", rd[1-m], 32'd0);
                    if (pend[m]) begin
                        oob = (cur[m].addr >= MEM_BYTES);
                        check("oob_flag", 32'(oob_err), 32'(oob));
                        if (cur[m].wstrb == 4'd0) begin
                            expd = oob ? 32'd0 : ref_mem[cur[m].addr[9:2]];
                            check(m ? "vec_rdata" : "cpu_rdata", rd[m], expd);
                        end else if (!oob) begin
                            for (int b = 0; b < 4; b++)
                                if (cur[m].wstrb[b])
                                    ref_mem[cur[m].addr[9:2]][8*b +: 8] = cur[m].wdata[8*b +: 8];
                        end
                        if (m == 0) res_cpu.push_back(rd[0]);
                        else        res_vec.push_back(rd[1]);
                        order.push_back(m);
                        gv.push_back(grant_vec);
                        if (first_lat[m] < 0) first_lat[m] = age[m];
                        pend[m] = 1'b0;
                        if (pend[1-m]) begin
                            wait_f[1-m]++;
                            check_le("fairness_wait", wait_f[1-m], 1);
                        end
                    end
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (pend[m]) begin
                    age[m]++;
                    check_le("req_age", age[m], 30);
                    if (age[m] > 30) abort = 1'b1;
                end
            end
            if (!pend[0] && !pend[1] && cpu_q.size() == 0 && vec_q.size() == 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("drain", 32'(cpu_q.size() + vec_q.size() + int'(pend[0]) + int'(pend[1])), 32'd0);
        cpu_q.delete(); vec_q.delete();
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int vv;
        req_t r;
        reset = 1'b1;
        cur[0] = '0; cur[1] = '0; pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(~i), 8'hA5, 8'(i * 3)};
        mem[0]   = 32'h01000113;
        mem[100] = 32'h04030201;
        mem[102] = 32'h0c0b0a09;
        mem[104] = 32'h14131211;
        mem[150] = 32'h00000093;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_instr", 32'(mem_instr), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_grant_vec", 32'(grant_vec), 32'd0);
        check("rst_oob_err", 32'(oob_err), 32'd0);
        check("rst_cpu_ready", 32'(cpu_mem_ready), 32'd0);
        check("rst_vec_ready", 32'(vec_mem_ready), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: CPU-only fetch
        cpu_q.push_back(mk(32'h0, 32'h0, 4'h0, 1'b1));
        run_traffic(50, 1'b0);
        check("t1_mv_cycles", 32'(mv_cycles), 32'd2);
        check("t1_cpu_count", 32'(res_cpu.size()), 32'd1);
        if (res_cpu.size() > 0) check("t1_rdata", res_cpu[0], 32'h01000113);
        check("t1_latency", 32'(first_lat[0]), 32'd2);
        check("t1_vec_count", 32'(res_vec.size()), 32'd0);

        // 2: tie, strict alternation starting with VEC
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cpu_q.push_back(mk(32'h20 + 32'(4 * i), 32'h0, 4'h0, 1'b0));
            vec_q.push_back(mk(32'h30 + 32'(4 * i), 32'h0, 4'h0, 1'b0));
        end
        run_traffic(100, 1'b0);
        check("t2_count", 32'(order.size()), 32'd6);
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            check("t2_order", 32'(order[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_grant_vec", 32'(gv[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        // 3: VEC strided loads while CPU fetches continuously
        for (int i = 0; i < 6; i++) cpu_q.push_back(mk(32'(4 * i), 32'h0, 4'h0, 1'b1));
        vec_q.push_back(mk(32'h190, 32'h0, 4'h0, 1'b0));
        vec_q.push_back(mk(32'h198, 32'h0, 4'h0, 1'b0));
        vec_q.push_back(mk(32'h1A0, 32'h0, 4'h0, 1'b0));
        run_traffic(200, 1'b0);
        check("t3_vec_count", 32'(res_vec.size()), 32'd3);
        check("t3_cpu_count", 32'(res_cpu.size()), 32'd6);
        if (res_vec.size() == 3) begin
            check("t3_vec0", res_vec[0], 32'h04030201);
            check("t3_vec1", res_vec[1], 32'h0c0b0a09);
            check("t3_vec2", res_vec[2], 32'h14131211);
        end
        vv = 0;
        for (int k = 1; k < order.size(); k++) if (order[k] == 1 && order[k-1] == 1) vv++;
        check("t3_vec_back_to_back", 32'(vv), 32'd0);

        // 4: VEC partial write, then CPU reads it back
        vec_q.push_back(mk(32'h258, 32'hDEADBEEF, 4'b0011, 1'b0));
        run_traffic(50, 1'b0);
        check("t4_ds_wstrb", 32'(last_vec_wstrb), 32'(4'b0011));
        cpu_q.push_back(mk(32'h258, 32'h0, 4'h0, 1'b0));
        run_traffic(50, 1'b0);
        if (res_cpu.size() > 0) check("t4_readback", res_cpu[0], 32'h0000BEEF);

        // 5: out-of-range CPU read answered locally, arbiter back to IDLE
        cpu_q.push_back(mk(32'h400, 32'h0, 4'h0, 1'b0));
        run_traffic(50, 1'b0);
        check("t5_mv_cycles", 32'(mv_cycles), 32'd0);
        check("t5_oob_pulses", 32'(oob_cnt), 32'd1);
        check("t5_cpu_count", 32'(res_cpu.size()), 32'd1);
        if (res_cpu.size() > 0) check("t5_rdata", res_cpu[0], 32'd0);
        cpu_q.push_back(mk(32'h4, 32'h0, 4'h0, 1'b0));
        run_traffic(50, 1'b0);
        check("t5_next_latency", 32'(first_lat[0]), 32'd2);

        // 6: reset while BUSY, then a stale mem_ready after release
        cur[0] = mk(32'h10, 32'h0, 4'h0, 1'b0); pend[0] = 1'b1;
        drive();
        vv = 0;
        for (int i = 0; i < 5 && vv == 0; i++) begin
            @(negedge clk);
            if (mem_valid) vv = 1;
        end
        check("t6_reached_busy", 32'(vv), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_mem_valid", 32'(mem_valid), 32'd0);
        check("t6_async_grant_vec", 32'(grant_vec), 32'd0);
        check("t6_async_cpu_ready", 32'(cpu_mem_ready), 32'd0);
        check("t6_async_mem_addr", mem_addr, 32'd0);
        pend[0] = 1'b0;
        drive();
        @(posedge clk); #1 reset = 1'b0;
        inject_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_stale_cpu_ready", 32'(cpu_mem_ready), 32'd0);
            check("t6_stale_vec_ready", 32'(vec_mem_ready), 32'd0);
            check("t6_stale_cpu_rdata", cpu_mem_rdata, 32'd0);
            check("t6_stale_mem_valid", 32'(mem_valid), 32'd0);
            @(posedge clk); #1 inject_ready = 1'b0;
        end

        // randomized traffic from both masters with wait states and bad addresses
        lat_en = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 150; i++) begin
                r.addr  = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h400)
                                                      : (32'($urandom_range(0, 255)) << 2);
                r.wdata = $urandom();
                r.wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                r.instr = (m == 0 && r.wstrb == 4'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (m == 0) cpu_q.push_back(r);
                else        vec_q.push_back(r);
            end
        end
        run_traffic(20000, 1'b1);
        check("rand_total", 32'(order.size()), 32'd300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
